// File: rtl/llc_prio_input_sched.sv
// llc_prio_input_sched: fixed-priority input scheduler for the LLC front end.
// Arbitrates NUM_CH channels plus a resume source into a DEPTH-entry decision
// FIFO whose head feeds the lookup stage over valid/ready.
// Optional feature macro: LLC_ISCHED_STARVE_EN (per-channel anti-starvation).
//
// state        | meaning
// count == 0   | FIFO empty, out_valid low
// 0<count<DEPTH| FIFO partially filled, push and pop both allowed
// count==DEPTH | FIFO full, grants suppressed until a pop
`ifndef LINE_ADDR_BITS
`define LINE_ADDR_BITS 16
`endif
`ifndef LLC_SET_BITS
`define LLC_SET_BITS 6
`endif

module llc_prio_input_sched #(
  parameter int NUM_CH     = 4,
  parameter int DEPTH      = 2,
  parameter int ADDR_W     = `LINE_ADDR_BITS,
  parameter int SET_BITS   = `LLC_SET_BITS,
  parameter int STARVE_MAX = 15,
  parameter int MATCH_CH   = 0,
  localparam int CH_W      = $clog2(NUM_CH + 1),
  localparam int TAG_W     = ADDR_W - SET_BITS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        ch_valid,
  input  logic [NUM_CH-1:0]        ch_block,
  input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
  output logic [NUM_CH-1:0]        ch_get,
  input  logic                     resume_valid,
  input  logic [ADDR_W-1:0]        resume_addr,
  output logic                     resume_ack,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_ch,
  output logic [TAG_W-1:0]         out_tag,
  output logic [SET_BITS-1:0]      out_set,
  input  logic                     stall_active,
  input  logic [TAG_W-1:0]         stall_tag,
  input  logic [SET_BITS-1:0]      stall_set,
  output logic                     clr_stall,
  output logic                     fifo_full,
  output logic                     idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CH_W-1:0]     mem_ch  [DEPTH];
  logic [TAG_W-1:0]    mem_tag [DEPTH];
  logic [SET_BITS-1:0] mem_set [DEPTH];
  logic [PTR_W-1:0]    rd_ptr, wr_ptr;
  logic [CNT_W-1:0]    count;

  logic [NUM_CH-1:0]   cand;
  logic [NUM_CH-1:0]   starved;
  logic                push, pop;
  logic [CH_W-1:0]     push_ch;
  logic [ADDR_W-1:0]   push_addr;

  assign cand      = ch_valid & ~ch_block;
  assign fifo_full = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign out_ch    = mem_ch[rd_ptr];
  assign out_tag   = mem_tag[rd_ptr];
  assign out_set   = mem_set[rd_ptr];
  assign pop       = out_valid & out_ready;
  assign push      = resume_ack | (|ch_get);
  assign idle      = ~(|cand) & ~resume_valid & ~out_valid;

  // Resume beats a match at the FIFO head only by channel id: resume entries
  // carry NUM_CH, which can never equal MATCH_CH.
  assign clr_stall = pop && (out_ch == CH_W'(MATCH_CH)) && stall_active &&
                     (out_tag == stall_tag) && (out_set == stall_set);

`ifdef LLC_ISCHED_STARVE_EN
  logic [7:0] starve_cnt [NUM_CH];

  // Starvation flag only counts while the channel is still a candidate.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++)
      starved[i] = cand[i] && (starve_cnt[i] >= 8'(STARVE_MAX));
  end

  // Saturating wait counters, cleared on grant or loss of candidacy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_get[i] || !cand[i])      starve_cnt[i] <= '0;
        else if (starve_cnt[i] != 8'hFF) starve_cnt[i] <= starve_cnt[i] + 8'd1;
      end
    end
  end
`else
  assign starved = '0;
`endif

  // Grant selection: resume, then lowest starved, then lowest candidate.
  always_comb begin
    int sel;
    logic found;
    ch_get     = '0;
    resume_ack = 1'b0;
    sel        = 0;
    found      = 1'b0;
    push_ch    = CH_W'(NUM_CH);
    push_addr  = resume_addr;
    if (!fifo_full) begin
      if (resume_valid) begin
        resume_ack = 1'b1;
      end else begin
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (cand[i]) begin
            sel   = i;
            found = 1'b1;
          end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
          if (starved[i]) sel = i;
        end
        if (found) begin
          ch_get[sel] = 1'b1;
          push_ch     = CH_W'(sel);
          push_addr   = ch_addr[sel*ADDR_W +: ADDR_W];
        end
      end
    end
  end

  // Circular decision FIFO; pointers wrap modulo DEPTH, no bypass when full.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_ch[i]  <= '0;
        mem_tag[i] <= '0;
        mem_set[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_ch[wr_ptr]  <= push_ch;
        mem_tag[wr_ptr] <= push_addr[ADDR_W-1:SET_BITS];
        mem_set[wr_ptr] <= push_addr[SET_BITS-1:0];
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_llc_prio_input_sched.sv
// Directed bench for llc_prio_input_sched (NUM_CH=4, DEPTH=2, 16-bit address,
// 6 set bits, STARVE_MAX=3, MATCH_CH=0).
module tb_llc_prio_input_sched;
  localparam int NUM_CH = 4;
  localparam int DEPTH  = 2;
  localparam int ADDR_W = 16;
  localparam int SET_B  = 6;
  localparam int TAG_W  = ADDR_W - SET_B;
  localparam int CH_W   = 3;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_valid = '0, ch_block = '0, ch_get;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic                     resume_valid = 1'b0, resume_ack;
  logic [ADDR_W-1:0]        resume_addr = 16'hABCD;
  logic                     out_valid, out_ready = 1'b0;
  logic [CH_W-1:0]          out_ch;
  logic [TAG_W-1:0]         out_tag, stall_tag = '0;
  logic [SET_B-1:0]         out_set, stall_set = '0;
  logic                     stall_active = 1'b0, clr_stall, fifo_full, idle;
  logic [ADDR_W-1:0]        chan_a [NUM_CH];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;
  assign ch_addr = {chan_a[3], chan_a[2], chan_a[1], chan_a[0]};

  llc_prio_input_sched #(
    .NUM_CH(NUM_CH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .SET_BITS(SET_B),
    .STARVE_MAX(3), .MATCH_CH(0)
  ) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_block(ch_block),
    .ch_addr(ch_addr), .ch_get(ch_get), .resume_valid(resume_valid),
    .resume_addr(resume_addr), .resume_ack(resume_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch), .out_tag(out_tag), .out_set(out_set),
    .stall_active(stall_active), .stall_tag(stall_tag), .stall_set(stall_set),
    .clr_stall(clr_stall), .fifo_full(fifo_full), .idle(idle)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_head(input string nm, input logic [ADDR_W-1:0] a);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_tag"}, 32'(out_tag), 32'(a[ADDR_W-1:SET_B]));
    chk({nm, "_set"}, 32'(out_set), 32'(a[SET_B-1:0]));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] v;
    logic [3:0] b;
    logic       rv;
    logic [3:0] get;
    logic       ack;
    logic       idl;
    logic [2:0] ch;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [ADDR_W-1:0] a;
    logic [ADDR_W-1:0] hist [11];

    vecs[0] = '{4'b1010, 4'b0000, 1'b0, 4'b0010, 1'b0, 1'b0, 3'd1};
    vecs[1] = '{4'b1010, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd4};
    vecs[2] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0};
    vecs[3] = '{4'b1111, 4'b0001, 1'b0, 4'b0010, 1'b0, 1'b0, 3'd1};
    vecs[4] = '{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b0, 3'd3};
    vecs[5] = '{4'b0110, 4'b0110, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd0};
    vecs[6] = '{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b0, 1'b0, 3'd0};
    vecs[7] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0, 3'd4};

    for (int i = 0; i < NUM_CH; i++) chan_a[i] = 16'h1111 * 16'(i + 1);

    // reset state
    #2 rst = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_ch", 32'(out_ch), 0);
    chk("rst_out_tag", 32'(out_tag), 0);
    chk("rst_out_set", 32'(out_set), 0);
    chk("rst_full", 32'(fifo_full), 0);
    chk("rst_idle", 32'(idle), 1);
    step();
    step();
    rst = 1'b1;

    // priority table, FIFO empty at every vector
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ch_valid = vecs[k].v; ch_block = vecs[k].b; resume_valid = vecs[k].rv;
      #1;
      chk($sformatf("vec%0d_get", k), 32'(ch_get), 32'(vecs[k].get));
      chk($sformatf("vec%0d_ack", k), 32'(resume_ack), 32'(vecs[k].ack));
      chk($sformatf("vec%0d_idle", k), 32'(idle), 32'(vecs[k].idl));
      step();
      ch_valid = '0; ch_block = '0; resume_valid = 1'b0;
      if (vecs[k].get != 0 || vecs[k].ack) begin
        a = (vecs[k].ch == 3'd4) ? resume_addr : chan_a[vecs[k].ch];
        chk($sformatf("vec%0d_out_ch", k), 32'(out_ch), 32'(vecs[k].ch));
        chk_head($sformatf("vec%0d_head", k), a);
      end else begin
        chk($sformatf("vec%0d_out_valid", k), 32'(out_valid), 0);
      end
      step();
    end

    // fill to full with out_ready low
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chan_a[0] = 16'h0100 + 16'(k) * 16'h0041;
      hist[k] = chan_a[0];
      ch_valid = 4'b0001;
      #1;
      chk($sformatf("fill%0d_get", k), 32'(ch_get), (k < 2) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_full", k), 32'(fifo_full), (k >= 2) ? 32'd1 : 32'd0);
      step();
    end
    ch_valid = '0;
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk_head($sformatf("drain%0d", k), hist[k]);
      step();
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_full", 32'(fifo_full), 0);

    // push/pop pairs across pointer wrap
    ch_valid = 4'b0001;
    for (int j = 0; j < 11; j++) begin
      chan_a[0] = 16'h2000 + 16'(j) * 16'h0103;
      hist[j] = chan_a[0];
      #1;
      chk($sformatf("pair%0d_get", j), 32'(ch_get), 1);
      if (j > 0) chk_head($sformatf("pair%0d", j), hist[j-1]);
      step();
    end
    ch_valid = '0;
    chk_head("pair_last", hist[10]);
    step();
    chk("pair_empty", 32'(out_valid), 0);

    // stall release
    stall_active = 1'b1; stall_tag = 10'h012; stall_set = 6'h3;
    out_ready = 1'b0;
    chan_a[0] = 16'h0483;
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    chk("stall_nopop", 32'(clr_stall), 0);
    out_ready = 1'b1;
    #1;
    chk("stall_ch0_pop", 32'(clr_stall), 1);
    step();
    chk("stall_after", 32'(clr_stall), 0);
    chan_a[2] = 16'h0483;
    ch_valid = 4'b0100;
    step();
    ch_valid = '0;
    chk("stall_ch2_out_ch", 32'(out_ch), 2);
    chk("stall_ch2", 32'(clr_stall), 0);
    step();
    resume_addr = 16'h0483;
    resume_valid = 1'b1;
    step();
    resume_valid = 1'b0;
    chk("stall_res_out_ch", 32'(out_ch), 4);
    chk("stall_res", 32'(clr_stall), 0);
    step();
    chan_a[0] = 16'h0484;
    ch_valid = 4'b0001;
    step();
    ch_valid = '0;
    chk("stall_set_mismatch", 32'(clr_stall), 0);
    step();
    stall_active = 1'b0;

    // starvation: channels 0 and 3 held valid
    ch_valid = 4'b1001;
    for (int c = 1; c <= 8; c++) begin
      #1;
`ifdef LLC_ISCHED_STARVE_EN
      chk($sformatf("starve_c%0d", c), 32'(ch_get), (c % 4 == 0) ? 32'h8 : 32'h1);
`else
      chk($sformatf("starve_c%0d", c), 32'(ch_get), 32'h1);
`endif
      @(posedge clk);
    end
    #1;
    ch_valid = '0;
    step();
    step();

    // reset mid-operation with two entries held
    out_ready = 1'b0;
    chan_a[0] = 16'h0222;
    ch_valid = 4'b0001;
    step();
    step();
    ch_valid = '0;
    chk("pre_rst_valid", 32'(out_valid), 1);
    chk("pre_rst_full", 32'(fifo_full), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_full", 32'(fifo_full), 0);
    chk("mid_rst_idle", 32'(idle), 1);
    chk("mid_rst_tag", 32'(out_tag), 0);
    step();
    rst = 1'b1;
    chan_a[0] = 16'h7FC5;
    ch_valid = 4'b0001;
    #1;
    chk("post_rst_get", 32'(ch_get), 1);
    step();
    ch_valid = '0;
    chk("post_rst_out_ch", 32'(out_ch), 0);
    chk_head("post_rst", 16'h7FC5);
    chk("post_rst_full", 32'(fifo_full), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
